window_reader: RTL

WINDOW_READER -- requirements
Module: window_reader

---
 rtl/window_reader.sv | 110 +++++++++++
 1 files changed

// File: rtl/window_reader.sv
// Sliding-window reader: pops one column per fetch from an upstream FIFO and presents
// KSIZE-column windows over a row pass of ROW_LEN columns, with abort/flush support.
module window_reader #(
    parameter int RES     = 8,
    parameter int WIDTH   = 3,
    parameter int KSIZE   = 3,
    parameter int ROW_LEN = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   abort,
    input  logic                                   fifo_empty,
    input  logic [WIDTH-1:0][RES-1:0]              fifo_data,
    output logic                                   fifo_rd_en,
    output logic                                   fifo_clear,
    output logic [KSIZE-1:0][WIDTH-1:0][RES-1:0]   win,
    output logic                                   win_valid,
    input  logic                                   win_ready,
    output logic                                   busy,
    output logic                                   done
);

    localparam int CNT_W = $clog2(ROW_LEN + 1);
    localparam logic [CNT_W-1:0] KSIZE_C   = CNT_W'(KSIZE);
    localparam logic [CNT_W-1:0] ROW_LEN_C = CNT_W'(ROW_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_OUT,
        S_DONE
    } state_e;

    typedef logic [KSIZE-1:0][WIDTH-1:0][RES-1:0] win_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] col_cnt_q, col_cnt_d;
    logic [CNT_W-1:0] col_inc;
    win_t             win_q, win_d;
    logic             done_q, done_d;
    logic             fifo_clear_q, fifo_clear_d;

    assign col_inc = col_cnt_q + CNT_W'(1);

    // State register together with the datapath registers it sequences.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            col_cnt_q    <= '0;
            // NOTE: the window registers are reset, not left undefined, because win must read zero after rst.
            win_q        <= '0;
            done_q       <= 1'b0;
            fifo_clear_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            col_cnt_q    <= col_cnt_d;
            win_q        <= win_d;
            done_q       <= done_d;
            fifo_clear_q <= fifo_clear_d;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (start) state_d = S_FETCH;
            S_FETCH:   if (!fifo_empty) state_d = S_CAPTURE;
            S_CAPTURE: state_d = (col_inc >= KSIZE_C) ? S_OUT : S_FETCH;
            S_OUT:     if (win_ready) state_d = (col_cnt_q == ROW_LEN_C) ? S_DONE : S_FETCH;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    // Column counter, window shift register and registered pulses.
    always_comb begin
        col_cnt_d    = col_cnt_q;
        win_d        = win_q;
        fifo_clear_d = abort;
        done_d       = (state_q == S_OUT) && win_ready && (col_cnt_q == ROW_LEN_C) && !abort;
        if (abort || (state_q == S_IDLE && start)) begin
            col_cnt_d = '0;
            win_d     = '0;
        end else if (state_q == S_CAPTURE) begin
            // fifo_data is valid here: the pop was issued in the preceding FETCH cycle.
            for (int i = 0; i < KSIZE - 1; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[KSIZE-1] = fifo_data;
            col_cnt_d      = col_inc;
        end
    end

    // Outputs.
    always_comb begin
        fifo_rd_en = (state_q == S_FETCH) && !fifo_empty;
        win_valid  = (state_q == S_OUT);
        busy       = (state_q != S_IDLE);
        win        = win_q;
        done       = done_q;
        fifo_clear = fifo_clear_q;
    end

endmodule
